// File: rtl/pong_pkg.sv
// Shared constants and encodings for the pong draw path.
// The optional BORDER_WALLS_EN build macro makes the screen clear leave
// white wall columns at WALL_X_LEFT and WALL_X_RIGHT.
package pong_pkg;

  // Screen and paddle geometry defaults
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int PADDLE_W_DEF = 25;
  localparam int PADDLE_Y_DEF = 117;

  // Wall columns painted white by the clear sweep when walls are enabled
  localparam logic [7:0] WALL_X_LEFT  = 8'd14;
  localparam logic [7:0] WALL_X_RIGHT = 8'd129;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  // Arbiter top-level states
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } draw_state_t;

  // Slot of the mod-3 schedule used in RUN
  typedef enum logic [1:0] {
    SLOT_BALL0  = 2'd0,
    SLOT_BALL1  = 2'd1,
    SLOT_PADDLE = 2'd2
  } slot_t;

  // Paddle engine sweep phase
  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_ERASE = 2'd1,
    PH_DRAW  = 2'd2
  } sweep_phase_t;

endpackage

// File: rtl/paddle_sweep.sv
// Paddle engine: each sweep latches the target column, optionally erases the
// previously drawn paddle (black) and then draws it at the target (white).
// Pixels run row PADDLE_Y columns 0..PADDLE_W-1, then row PADDLE_Y+1.
module paddle_sweep
  import pong_pkg::*;
#(
  parameter int PADDLE_W = PADDLE_W_DEF,
  parameter int PADDLE_Y = PADDLE_Y_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       abort,
  input  logic       start,
  input  logic       step,
  input  logic [7:0] target_x,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic [2:0] pix_colour,
  output logic       pix_valid,
  output logic       done,
  output logic [1:0] phase_dbg
);

  // Handshake: pix_* describes the current pixel whenever pix_valid is high;
  // the pixel is consumed (and the engine advances) on a cycle where step and
  // pix_valid are both high. start launches a new sweep when the engine is
  // idle or is consuming its final pixel (done), so sweeps chain gap-free.
  // abort returns to idle at once; drawn_x keeps the last completed paddle.

  localparam int COL_W = (PADDLE_W > 1) ? $clog2(PADDLE_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PADDLE_W - 1);

  sweep_phase_t     phase, phase_n;
  logic [COL_W-1:0] col, col_n;
  logic             row, row_n;
  logic [7:0]       base_x, base_x_n;
  logic [7:0]       latch_x, latch_x_n;
  logic [7:0]       drawn_x, drawn_x_n;
  logic             last_pix;
  logic             launch;
  logic [7:0]       drawn_eff;

  assign last_pix  = (col == COL_LAST) && row;
  assign done      = (phase == PH_DRAW) && step && last_pix && !abort;
  // When a sweep finishes this cycle, the new sweep compares against the
  // position that is just becoming the drawn one.
  assign drawn_eff = done ? latch_x : drawn_x;
  assign launch    = start && !abort && ((phase == PH_IDLE) || done);

  // Next-state: launch, advance through erase/draw pixels, or abort
  always_comb begin
    phase_n   = phase;
    col_n     = col;
    row_n     = row;
    base_x_n  = base_x;
    latch_x_n = latch_x;
    drawn_x_n = drawn_x;
    if (abort) begin
      phase_n = PH_IDLE;
      col_n   = '0;
      row_n   = 1'b0;
    end else begin
      if (done) drawn_x_n = latch_x;
      if (launch) begin
        latch_x_n = target_x;
        col_n     = '0;
        row_n     = 1'b0;
        if (target_x != drawn_eff) begin
          phase_n  = PH_ERASE;
          base_x_n = drawn_eff;
        end else begin
          phase_n  = PH_DRAW;
          base_x_n = target_x;
        end
      end else if (step && (phase != PH_IDLE)) begin
        if (last_pix) begin
          col_n = '0;
          row_n = 1'b0;
          if (phase == PH_ERASE) begin
            phase_n  = PH_DRAW;
            base_x_n = latch_x;
          end else begin
            phase_n = PH_IDLE;
          end
        end else if (col == COL_LAST) begin
          col_n = '0;
          row_n = 1'b1;
        end else begin
          col_n = col + COL_W'(1);
        end
      end
    end
  end

  // Sweep registers; drawn_x reset-loads the clamped paddle position so the
  // first sweep after reset only draws
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase   <= PH_IDLE;
      col     <= '0;
      row     <= 1'b0;
      base_x  <= 8'd0;
      latch_x <= 8'd0;
      drawn_x <= target_x;
    end else begin
      phase   <= phase_n;
      col     <= col_n;
      row     <= row_n;
      base_x  <= base_x_n;
      latch_x <= latch_x_n;
      drawn_x <= drawn_x_n;
    end
  end

  assign pix_x      = base_x + 8'(col);
  assign pix_y      = 7'(PADDLE_Y) + 7'(row);
  assign pix_colour = (phase == PH_ERASE) ? COLOUR_BLACK : COLOUR_WHITE;
  assign pix_valid  = (phase != PH_IDLE);
  assign phase_dbg  = phase;

endmodule

// File: rtl/pong_draw_arbiter.sv
// Pong draw arbiter: owns the single VGA write port. After reset and on each
// game_over rising edge it clears the screen one pixel per cycle; otherwise
// it interleaves the ball pixel stream (two slots of three) with the paddle
// engine (one slot of three). All vga_* outputs are registered.
// Build option BORDER_WALLS_EN: clear paints wall columns white.
module pong_draw_arbiter
  import pong_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int PADDLE_W = PADDLE_W_DEF,
  parameter int PADDLE_Y = PADDLE_Y_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic [2:0] ball_colour,
  input  logic [7:0] paddle_x,
  input  logic       game_over,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy_clear,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] X_LAST    = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST    = 7'(SCREEN_H - 1);
  localparam logic [7:0] PADDLE_XM = 8'(SCREEN_W - PADDLE_W);

  draw_state_t state, state_n;
  slot_t       slot, slot_n;
  logic [7:0]  clr_x, clr_x_n;
  logic [6:0]  clr_y, clr_y_n;
  logic        go_q;
  logic        go_edge;
  logic [2:0]  clear_colour;
  logic        ball_ok;
  logic [7:0]  target_x;

  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_colour;
  logic        sel_plot;

  logic [7:0]  pad_x;
  logic [6:0]  pad_y;
  logic [2:0]  pad_colour;
  logic        pad_valid;
  logic        pad_done;
  logic [1:0]  pad_phase;
  logic        pad_abort;
  logic        pad_start;
  logic        pad_step;

  assign go_edge  = game_over && !go_q;
  assign ball_ok  = (ball_x < 8'(SCREEN_W)) && (ball_y < 7'(SCREEN_H));
  assign target_x = (paddle_x > PADDLE_XM) ? PADDLE_XM : paddle_x;

`ifdef BORDER_WALLS_EN
  assign clear_colour = ((clr_x == WALL_X_LEFT) || (clr_x == WALL_X_RIGHT)) ?
                        COLOUR_WHITE : COLOUR_BLACK;
`else
  assign clear_colour = COLOUR_BLACK;
`endif

  // The engine only runs in RUN; it advances on the paddle slot. A new sweep
  // starts whenever it is idle or finishing, so no paddle slot is wasted.
  assign pad_abort = (state != ST_RUN);
  assign pad_step  = (state == ST_RUN) && (slot == SLOT_PADDLE);
  assign pad_start = (state == ST_RUN) && (!pad_valid || pad_done);

  paddle_sweep #(
    .PADDLE_W (PADDLE_W),
    .PADDLE_Y (PADDLE_Y)
  ) u_paddle (
    .clock      (clock),
    .resetn     (resetn),
    .abort      (pad_abort),
    .start      (pad_start),
    .step       (pad_step),
    .target_x   (target_x),
    .pix_x      (pad_x),
    .pix_y      (pad_y),
    .pix_colour (pad_colour),
    .pix_valid  (pad_valid),
    .done       (pad_done),
    .phase_dbg  (pad_phase)
  );

  // Next-state and pixel selection for the CLEAR/RUN arbiter
  always_comb begin
    state_n    = state;
    slot_n     = slot;
    clr_x_n    = clr_x;
    clr_y_n    = clr_y;
    sel_x      = 8'd0;
    sel_y      = 7'd0;
    sel_colour = COLOUR_BLACK;
    sel_plot   = 1'b0;
    case (state)
      ST_CLEAR: begin
        // Inputs and game_over edges are ignored until the sweep finishes
        sel_x      = clr_x;
        sel_y      = clr_y;
        sel_colour = clear_colour;
        sel_plot   = 1'b1;
        slot_n     = SLOT_BALL0;
        if (clr_x == X_LAST) begin
          clr_x_n = 8'd0;
          if (clr_y == Y_LAST) begin
            clr_y_n = 7'd0;
            state_n = ST_RUN;
          end else begin
            clr_y_n = clr_y + 7'd1;
          end
        end else begin
          clr_x_n = clr_x + 8'd1;
        end
      end
      ST_RUN: begin
        case (slot)
          SLOT_BALL0: slot_n = SLOT_BALL1;
          SLOT_BALL1: slot_n = SLOT_PADDLE;
          default:    slot_n = SLOT_BALL0;
        endcase
        if (slot == SLOT_PADDLE) begin
          if (pad_valid) begin
            sel_x      = pad_x;
            sel_y      = pad_y;
            sel_colour = pad_colour;
            sel_plot   = 1'b1;
          end
        end else if (ball_ok) begin
          // Off-screen ball pixels are dropped rather than forwarded
          sel_x      = ball_x;
          sel_y      = ball_y;
          sel_colour = ball_colour;
          sel_plot   = 1'b1;
        end
        if (go_edge) begin
          state_n = ST_CLEAR;
          slot_n  = SLOT_BALL0;
          clr_x_n = 8'd0;
          clr_y_n = 7'd0;
        end
      end
      default: begin
        state_n = ST_CLEAR;
        slot_n  = SLOT_BALL0;
        clr_x_n = 8'd0;
        clr_y_n = 7'd0;
      end
    endcase
  end

  // State, slot, clear counters and game_over history
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_CLEAR;
      slot  <= SLOT_BALL0;
      clr_x <= 8'd0;
      clr_y <= 7'd0;
      go_q  <= 1'b0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
      clr_x <= clr_x_n;
      clr_y <= clr_y_n;
      go_q  <= game_over;
    end
  end

  // Registered VGA write; busy_clear is registered alongside so it flags
  // exactly the writes produced by a clear sweep
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= COLOUR_BLACK;
      vga_plot   <= 1'b0;
      busy_clear <= 1'b1;
    end else begin
      vga_x      <= sel_x;
      vga_y      <= sel_y;
      vga_colour <= sel_colour;
      vga_plot   <= sel_plot;
      busy_clear <= (state == ST_CLEAR);
    end
  end

  assign state_dbg = {pad_phase, state};

endmodule
